// File: rtl/gray_frame_sequencer.sv
// Frame sequencer: for every pixel, read RGB from the source buffer, run it through the
// gray converter and write the result out. Define GRAY_SEQ_CONTINUOUS_EN to repeat frames.
module gray_frame_sequencer #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15,
  parameter int RD_LAT  = 1,
  parameter int CVT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              cvt_valid,
  output logic [7:0]        cvt_r,
  output logic [7:0]        cvt_g,
  output logic [7:0]        cvt_b,
  input  logic [7:0]        cvt_gray,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready
);

  typedef enum logic [2:0] {IDLE, READ, MEMWAIT, CVT, CVTWAIT, WRITE} state_t;

  localparam int                NPIX     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  localparam int                MAX_LAT  = (RD_LAT > CVT_LAT) ? RD_LAT : CVT_LAT;
  localparam int                CNT_W    = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0]  MEM_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CVT_LAST = CNT_W'(CVT_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [7:0]        gray_q, gray_d;
  logic              done_q, done_d;

  // NOTE: data registers are reset as well, since cvt_r/g/b expose them and must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rgb_q   <= '0;
      gray_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
      gray_q  <= gray_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rgb_d   = rgb_q;
    gray_d  = gray_q;
    done_d  = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = READ;
            idx_d   = '0;
          end
        end
        READ: begin
          state_d = MEMWAIT;
          cnt_d   = '0;
        end
        MEMWAIT: begin
          if (cnt_q == MEM_LAST) begin
            rgb_d   = rd_data;
            state_d = CVT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CVT: begin
          state_d = CVTWAIT;
          cnt_d   = '0;
        end
        CVTWAIT: begin
          if (cnt_q == CVT_LAST) begin
            gray_d  = cvt_gray;
            state_d = WRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (idx_q == LAST_IDX) begin
              done_d = 1'b1;
`ifdef GRAY_SEQ_CONTINUOUS_EN
              state_d = READ;
              idx_d   = '0;
`else
              state_d = IDLE;
`endif
            end else begin
              state_d = READ;
              idx_d   = idx_q + ADDR_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Addresses and write data are forced to 0 outside their strobe state.
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_en     = (state_q == READ);
  assign rd_addr   = rd_en ? idx_q : '0;
  assign cvt_valid = (state_q == CVT);
  assign cvt_r     = rgb_q[23:16];
  assign cvt_g     = rgb_q[15:8];
  assign cvt_b     = rgb_q[7:0];
  assign wr_en     = (state_q == WRITE);
  assign wr_addr   = wr_en ? idx_q : '0;
  assign wr_data   = wr_en ? gray_q : 8'd0;

endmodule
